// File: rtl/udp_seg_arbiter.sv
// Packet-level round-robin arbiter: NUM_CH Avalon-ST UDP sources share one segmenter port.
// Define UDP_SEG_ARB_PKT_CNT_EN to build the per-channel packet counters at word 0x8+c.
module udp_seg_arbiter #(
  parameter int NUM_CH = 4,
  parameter int GAP_W  = 16
) (
  input  logic                  csi_clock_clk,
  input  logic                  csi_clock_reset_n,
  input  logic                  avs_s0_write,
  input  logic                  avs_s0_read,
  input  logic [3:0]            avs_s0_address,
  input  logic [3:0]            avs_s0_byteenable,
  input  logic [31:0]           avs_s0_writedata,
  output logic [31:0]           avs_s0_readdata,
  output logic [NUM_CH-1:0]     asi_snk0_ready,
  input  logic [32*NUM_CH-1:0]  asi_snk0_data,
  input  logic [NUM_CH-1:0]     asi_snk0_valid,
  input  logic [NUM_CH-1:0]     asi_snk0_startofpacket,
  input  logic [NUM_CH-1:0]     asi_snk0_endofpacket,
  input  logic [2*NUM_CH-1:0]   asi_snk0_empty,
  input  logic                  aso_src0_ready,
  output logic [31:0]           aso_src0_data,
  output logic                  aso_src0_valid,
  output logic                  aso_src0_startofpacket,
  output logic                  aso_src0_endofpacket,
  output logic [1:0]            aso_src0_empty,
  output logic [2:0]            aso_src0_channel
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ARB, PASS, GAP} state_t;

  state_t            state_q;
  logic [CW-1:0]     grant_q;
  logic [CW-1:0]     rr_ptr_q;
  logic              enable_q;
  logic [NUM_CH-1:0] mask_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_len_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              err_q;
  logic [GAP_W-1:0]  gap_d;

  logic [31:0]       snk_data  [NUM_CH];
  logic [1:0]        snk_empty [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] drain;
  logic              in_arb;
  logic              in_pass;
  logic              eop_xfer;
  logic              arb_found;
  logic [CW-1:0]     arb_idx;
  logic [31:0]       cnt_rdata;
  logic              unused_ok;

  assign in_arb  = (state_q == ARB);
  assign in_pass = (state_q == PASS);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign snk_data[gi]  = asi_snk0_data[32*gi +: 32];
    assign snk_empty[gi] = asi_snk0_empty[2*gi +: 2];
    assign req[gi]   = enable_q & mask_q[gi] & asi_snk0_valid[gi] & asi_snk0_startofpacket[gi];
    assign drain[gi] = enable_q & mask_q[gi] & asi_snk0_valid[gi] & ~asi_snk0_startofpacket[gi];
    // Mid-packet beats seen while idle are swallowed so a broken source cannot wedge its lane.
    assign asi_snk0_ready[gi] = in_arb ? drain[gi]
                                       : (in_pass & (grant_q == CW'(gi)) & aso_src0_ready);
  end

  assign aso_src0_data          = in_pass ? snk_data[grant_q] : '0;
  assign aso_src0_valid         = in_pass & asi_snk0_valid[grant_q];
  assign aso_src0_startofpacket = in_pass & asi_snk0_startofpacket[grant_q];
  assign aso_src0_endofpacket   = in_pass & asi_snk0_endofpacket[grant_q];
  assign aso_src0_empty         = in_pass ? snk_empty[grant_q] : '0;
  assign aso_src0_channel       = in_pass ? 3'(grant_q) : 3'd0;

  assign eop_xfer = aso_src0_valid & aso_src0_endofpacket & aso_src0_ready;

  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_idx   = CW'(idx);
      end
    end
  end

  always_comb begin
    gap_d = gap_q;
    for (int i = 0; i < GAP_W; i++) begin
      if (avs_s0_byteenable[i/8]) gap_d[i] = avs_s0_writedata[i];
    end
  end

  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      state_q   <= ARB;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      enable_q  <= 1'b0;
      mask_q    <= '1;
      gap_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (arb_found) begin
            grant_q  <= arb_idx;
            rr_ptr_q <= (arb_idx == CW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
            state_q  <= PASS;
          end
        end
        PASS: begin
          if (eop_xfer) begin
            gap_cnt_q <= '0;
            gap_len_q <= gap_q;
            state_q   <= (gap_q != '0) ? GAP : ARB;
          end
        end
        GAP: begin
          // The gap length is latched on entry so a mid-gap write only affects the next gap.
          if (aso_src0_ready) begin
            if (gap_cnt_q == gap_len_q - GAP_W'(1)) state_q <= ARB;
            else gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase

      if (avs_s0_write && avs_s0_address == 4'h0) begin
        if (avs_s0_byteenable[0]) enable_q <= avs_s0_writedata[0];
        if (avs_s0_byteenable[1]) mask_q   <= avs_s0_writedata[8 +: NUM_CH];
      end
      if (avs_s0_write && avs_s0_address == 4'h1) gap_q <= gap_d;

      if (in_arb && (|drain)) err_q <= 1'b1;
      else if (avs_s0_write && avs_s0_address == 4'h2 &&
               avs_s0_byteenable[1] && avs_s0_writedata[8]) err_q <= 1'b0;
    end
  end

`ifdef UDP_SEG_ARB_PKT_CNT_EN
  logic [31:0] pkt_cnt_q [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
      if (!csi_clock_reset_n) pkt_cnt_q[gi] <= '0;
      else if (avs_s0_write && avs_s0_address == 4'(8 + gi)) pkt_cnt_q[gi] <= '0;
      else if (eop_xfer && grant_q == CW'(gi)) pkt_cnt_q[gi] <= pkt_cnt_q[gi] + 32'd1;
    end
  end

  always_comb begin
    cnt_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs_s0_address == 4'(8 + c)) cnt_rdata = pkt_cnt_q[c];
    end
  end
`else
  assign cnt_rdata = '0;
`endif

  always_comb begin
    avs_s0_readdata = '0;
    case (avs_s0_address)
      4'h0: begin
        avs_s0_readdata[0]           = enable_q;
        avs_s0_readdata[8 +: NUM_CH] = mask_q;
      end
      4'h1: avs_s0_readdata[GAP_W-1:0] = gap_q;
      4'h2: begin
        avs_s0_readdata[0]   = ~in_arb;
        avs_s0_readdata[6:4] = 3'(grant_q);
        avs_s0_readdata[8]   = err_q;
      end
      default: avs_s0_readdata = cnt_rdata;
    endcase
  end

  assign unused_ok = ^{avs_s0_read, avs_s0_writedata, avs_s0_byteenable};
endmodule

// File: doc/udp_seg_arbiter.md
Name: udp_seg_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single IP segmentation engine between NUM_CH UDP packet sources.
- Sits directly upstream of the segmenter. Has NUM_CH Avalon-ST sinks and one Avalon-ST source.
- Holds a grant for one whole packet, from SOP to accepted EOP, then inserts a programmable inter-packet gap.
- Avalon-MM slave provides enable, channel mask, gap length, status and per-channel packet counters.

Parameters:
- NUM_CH, 4, number of requester channels (legal 2..8).
- GAP_W, 16, width of the inter-packet gap counter and register.

Ports:
- csi_clock_clk  in  1  clock.
- csi_clock_reset_n  in  1  asynchronous active-low reset.
- avs_s0_write  in  1  register write strobe.
- avs_s0_read  in  1  register read strobe.
- avs_s0_address  in  4  word address.
- avs_s0_byteenable  in  4  byte enables.
- avs_s0_writedata  in  32  write data.
- avs_s0_readdata  out  32  read data, combinational from address.
- asi_snk0_ready  out  NUM_CH  per-channel ready.
- asi_snk0_data  in  32*NUM_CH  channel c at bits [32c+:32].
- asi_snk0_valid  in  NUM_CH  per-channel valid.
- asi_snk0_startofpacket  in  NUM_CH  per-channel SOP.
- asi_snk0_endofpacket  in  NUM_CH  per-channel EOP.
- asi_snk0_empty  in  2*NUM_CH  channel c at bits [2c+:2].
- aso_src0_ready  in  1  segmenter ready.
- aso_src0_data  out  32  muxed data.
- aso_src0_valid  out  1  muxed valid.
- aso_src0_startofpacket  out  1  muxed SOP.
- aso_src0_endofpacket  out  1  muxed EOP.
- aso_src0_empty  out  2  muxed empty.
- aso_src0_channel  out  3  index of the granted channel.

Behaviour:
- Reset (async, csi_clock_reset_n=0):
  - State ARB; grant=0; rr_ptr=0; enable=0; mask=all ones; gap=0; gap_cnt=0; err=0; counters=0.
  - All aso_src0_* outputs and all asi_snk0_ready bits are 0.
- Handshake: Avalon-ST with ready latency 0. A beat transfers when valid & ready are both high in the same cycle.
- States:
  - ARB:
    - A channel requests when enable & mask[c] & valid[c] & sop[c].
    - Search starts at rr_ptr, ascending, wrapping at NUM_CH-1 to 0. The first requester is registered as grant, with rr_ptr <= grant+1 mod NUM_CH; go to PASS.
    - Grant latency: one cycle from the request to the first PASS cycle.
    - All outputs are 0 in ARB. asi_snk0_ready is 0, except for the drain case below.
  - PASS:
    - aso_src0_{data,valid,sop,eop,empty} = sink[grant] (combinational mux).
    - asi_snk0_ready[grant] = aso_src0_ready; all other ready bits are 0.
    - aso_src0_channel = grant, held constant for the whole packet.
    - When the EOP beat transfers: increment pkt_cnt[grant]. Go to GAP if gap≠0, otherwise go to ARB.
  - GAP:
    - Outputs 0; gap_cnt counts up to gap-1, then go to ARB.
    - gap_cnt clears on GAP entry. Counting runs only while aso_src0_ready=1, so it stalls with the downstream.
- Drain: in ARB, any channel with enable & mask[c] & valid[c] & ~sop[c] gets ready=1. Its beat is discarded and status.err is set (sticky).
- Single-beat packet (SOP&EOP): passes in one PASS cycle, then GAP or ARB.
- Clearing enable or a mask bit mid-packet: the current packet completes; the change applies at the next ARB.
- Writing gap mid-GAP: takes effect from the next GAP entry.
- SOP seen again on the granted channel before EOP: forwarded unchanged. The arbiter does not police framing inside a grant.
- Register map (word addresses):
  - 0x0 CTRL, read/write:
    - bit0 enable, byte0.
    - bits[8+:NUM_CH] mask, byte1.
  - 0x1 GAP, read/write: [GAP_W-1:0] gap cycles, bytes 0–1.
  - 0x2 STATUS:
    - Read: bit0 busy (state≠ARB), bits[6:4] grant, bit8 err.
    - A write with writedata[8]=1 and byteenable[1]=1 clears err.
  - 0x8+c PKT_CNT[c], read-only, 32-bit wrap-around. Present only with the optional feature.
  - Unmapped addresses read 0.
- Counter wrap: 0xFFFFFFFF+1 → 0, no saturation.
- Simultaneous err set (drain) and err clear write: set wins.

Optional Feature:
- Macro: UDP_SEG_ARB_PKT_CNT_EN.
- Defined: the NUM_CH 32-bit PKT_CNT registers exist. A write of any value to 0x8+c clears counter c; if the write and an increment land in the same cycle, the clear wins.
- Undefined: no counter logic is built and 0x8–0xF read 0.

Test Plan:
- enable=1, mask=0xF, gap=0; ch1 and ch2 each send a 3-beat packet from the same cycle → ch1 then ch2 back-to-back, one ARB cycle between them; channel=1 then 2; PKT_CNT1=PKT_CNT2=1.
- All 4 channels continuously requesting 1-beat packets, 8 packets → grant order 0,1,2,3,0,1,2,3.
- gap=5, ch0 sends two 2-beat packets with aso_src0_ready=1 → exactly 5 GAP cycles plus 1 ARB cycle between the EOP transfer and the next SOP.
- Toggle aso_src0_ready every cycle during a 6-beat packet from ch3 → all 6 beats arrive in order; no beat from another channel is interleaved; the stall is reflected on asi_snk0_ready[3].
- ch2 presents valid without SOP in ARB → beat discarded, STATUS.err=1; write 0x100 to STATUS → err=0.
- Assert reset mid-packet → all outputs 0 immediately (async); after release a new SOP on ch0 is granted first with PKT_CNT0=0.
